// File: rtl/std_op_sequencer.sv
// Sequences operand pairs from a 2-entry FIFO through an external go/done
// multicycle unit, one operation at a time, and holds each result for downstream.
module std_op_sequencer #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_left,
  input  logic [width-1:0] in_right,
  output logic             unit_go,
  output logic [width-1:0] unit_left,
  output logic [width-1:0] unit_right,
  input  logic [width-1:0] unit_out,
  input  logic             unit_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RELEASE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [width-1:0] r_fifo_left  [2];
  logic [width-1:0] r_fifo_right [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             r_unit_go;
  logic [width-1:0] r_unit_left;
  logic [width-1:0] r_unit_right;
  logic             r_out_valid;
  logic [width-1:0] r_out_data;
  logic             w_push;
  logic             w_issue;
  logic             w_capture;
  logic             w_consume;

  // Full FIFO refuses a push even when the same edge pops it.
  assign in_ready  = (r_count != 2'd2);
  assign w_push    = in_valid && in_ready;
  assign w_capture = (r_state == S_ISSUE) && unit_done;
  assign w_consume = r_out_valid && out_ready;

  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_count != 2'd0) && (!r_out_valid || out_ready)) begin
          w_issue     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (unit_done) w_state_nxt = S_RELEASE;
      end
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: FIFO storage carries no reset; occupancy is tracked by r_count, so
  // stale entries are never read and the array can map to plain storage.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_left[r_wr_ptr]  <= in_left;
      r_fifo_right[r_wr_ptr] <= in_right;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push)  r_wr_ptr <= ~r_wr_ptr;
      if (w_issue) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Go and operands are held for the whole ISSUE state, then cleared on done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_unit_go    <= 1'b0;
      r_unit_left  <= '0;
      r_unit_right <= '0;
    end else if (w_issue) begin
      r_unit_go    <= 1'b1;
      r_unit_left  <= r_fifo_left[r_rd_ptr];
      r_unit_right <= r_fifo_right[r_rd_ptr];
    end else if (w_capture) begin
      r_unit_go    <= 1'b0;
      r_unit_left  <= '0;
      r_unit_right <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_data  <= unit_out;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  assign unit_go    = r_unit_go;
  assign unit_left  = r_unit_left;
  assign unit_right = r_unit_right;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_std_op_sequencer.sv
// Bench for std_op_sequencer: behavioural go/done unit models (multiplier,
// divider) plus an in-order scoreboard of expected results.
module tb_std_op_sequencer;
  localparam int W = 32;

  typedef enum {U_MUL, U_DIV} unit_kind_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_left = '0;
  logic [W-1:0] in_right = '0;
  logic         unit_go;
  logic [W-1:0] unit_left;
  logic [W-1:0] unit_right;
  logic [W-1:0] unit_out;
  logic         unit_done;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         busy;

  std_op_sequencer #(.width(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left), .in_right(in_right),
    .unit_go(unit_go), .unit_left(unit_left), .unit_right(unit_right),
    .unit_out(unit_out), .unit_done(unit_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  unit_kind_t   mode = U_MUL;
  int           div_lat_fixed = 0;
  logic         spurious = 1'b0;

  function automatic logic [W-1:0] op_ref(input logic [W-1:0] l, input logic [W-1:0] r);
    if (mode == U_MUL) return l * r;
    return (r == 0) ? '1 : l / r;
  endfunction

  // Attached unit: counts go-high cycles, pulses done once, re-arms when go drops.
  logic         m_done = 1'b0;
  logic [W-1:0] m_out = '0;
  int           m_cnt = 0;
  int           m_lat = 3;
  bit           m_fired = 1'b0;

  always @(negedge clk) begin
    m_done = 1'b0;
    m_out  = $urandom;
    if (!unit_go) begin
      m_cnt   = 0;
      m_fired = 1'b0;
    end else if (!m_fired) begin
      if (m_cnt == 0)
        m_lat = (mode == U_MUL) ? 3 :
                (div_lat_fixed != 0) ? div_lat_fixed : int'($urandom_range(2, 8));
      m_cnt++;
      if (m_cnt == m_lat) begin
        m_done  = 1'b1;
        m_out   = op_ref(unit_left, unit_right);
        m_fired = 1'b1;
      end
    end
  end

  assign unit_done = m_done | spurious;
  assign unit_out  = spurious ? 32'hdead_beef : m_out;

  int           n_total = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_q[$];
  int           n_push = 0;
  int           n_issue = 0;
  logic         prev_go = 1'b0;
  logic [W-1:0] prev_l = '0;
  logic [W-1:0] prev_r = '0;
  bit           saw_out = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One cycle: drive at the falling edge, observe registered outputs, update the model.
  task automatic drive(input logic v, input logic [W-1:0] l, input logic [W-1:0] r,
                       input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_left   = l;
    in_right  = r;
    out_ready = ordy;
    if (unit_go && !prev_go) n_issue++;
    if (unit_go && prev_go) begin
      check("op_left_hold", unit_left, prev_l);
      check("op_right_hold", unit_right, prev_r);
    end
    if (!unit_go) begin
      check("op_left_idle", unit_left, 32'd0);
      check("op_right_idle", unit_right, 32'd0);
    end
    check("in_ready", 32'(in_ready), 32'((n_push - n_issue) < 2));
    saw_out = out_valid;
    if (v && in_ready) begin
      exp_q.push_back(op_ref(l, r));
      n_push++;
    end
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) check("out_extra", 32'(out_valid), 32'd0);
      else                   check("out_data", out_data, exp_q.pop_front());
    end
    prev_go = unit_go;
    prev_l  = unit_left;
    prev_r  = unit_right;
  endtask

  task automatic clear_model();
    exp_q.delete();
    n_push  = 0;
    n_issue = 0;
    prev_go = 1'b0;
    prev_l  = '0;
    prev_r  = '0;
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    spurious  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_go", 32'(unit_go), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_left", unit_left, 32'd0);
    clear_model();
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic run_until_out(input string tag, input int max_cyc, input logic [W-1:0] exp);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      if (saw_out) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_seen"}, 32'(got), 32'd1);
    if (got) check(tag, out_data, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;

    // Multiplier, single op: latency, one-cycle result pulse, one-cycle release.
    mode = U_MUL;
    apply_reset();
    drive(1'b1, 32'd6, 32'd7, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      if (unit_go) begin seen = 1'b1; break; end
    end
    check("mul_go_seen", 32'(seen), 32'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      n++;
      if (saw_out) break;
    end
    check("mul_latency", 32'(n), 32'd3);
    check("mul_out", out_data, 32'd42);
    check("mul_release_go", 32'(unit_go), 32'd0);
    check("mul_release_busy", 32'(busy), 32'd1);
    drive(1'b0, '0, '0, 1'b1);
    check("mul_pulse", 32'(out_valid), 32'd0);
    check("mul_idle_busy", 32'(busy), 32'd0);
    check("mul_idle_go", 32'(unit_go), 32'd0);

    // Divider, back-to-back pushes until full, then in-order results.
    mode = U_DIV;
    div_lat_fixed = 5;
    drive(1'b1, 32'd100, 32'd7, 1'b1);
    drive(1'b1, 32'd45, 32'd9, 1'b1);
    drive(1'b1, 32'd0, 32'd5, 1'b1);
    drive(1'b1, 32'd77, 32'd1, 1'b1);
    check("div_full_ready", 32'(in_ready), 32'd0);
    run_until_out("div_first", 40, 32'd14);
    run_until_out("div_second", 40, 32'd5);
    run_until_out("div_third", 40, 32'd0);

    // Held result blocks issue; consumption and issue share an edge.
    mode = U_MUL;
    drive(1'b1, 32'd2, 32'd3, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, '0, '0, 1'b0);
      if (saw_out) begin seen = 1'b1; break; end
    end
    check("hold_seen", 32'(seen), 32'd1);
    drive(1'b1, 32'd4, 32'd5, 1'b0);
    drive(1'b1, 32'd6, 32'd7, 1'b0);
    drive(1'b1, 32'd8, 32'd9, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 1'b0);
      check("hold_go", 32'(unit_go), 32'd0);
      check("hold_data", out_data, 32'd6);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    drive(1'b0, '0, '0, 1'b1);
    drive(1'b0, '0, '0, 1'b0);
    check("same_cycle_issue_go", 32'(unit_go), 32'd1);
    check("same_cycle_issue_valid", 32'(out_valid), 32'd0);
    run_until_out("hold_next1", 20, 32'd20);
    run_until_out("hold_next2", 20, 32'd42);
    repeat (3) drive(1'b0, '0, '0, 1'b1);

    // Spurious done while idle is ignored.
    spurious = 1'b1;
    drive(1'b0, '0, '0, 1'b1);
    spurious = 1'b0;
    check("spur_valid", 32'(out_valid), 32'd0);
    check("spur_busy", 32'(busy), 32'd0);
    check("spur_go", 32'(unit_go), 32'd0);
    drive(1'b0, '0, '0, 1'b1);
    check("spur_valid2", 32'(out_valid), 32'd0);

    // Reset during ISSUE discards the operation and the queued pair.
    mode = U_DIV;
    div_lat_fixed = 8;
    drive(1'b1, 32'd100, 32'd7, 1'b1);
    drive(1'b1, 32'd45, 32'd9, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      if (unit_go) begin seen = 1'b1; break; end
    end
    check("rst_issue_seen", 32'(seen), 32'd1);
    drive(1'b0, '0, '0, 1'b1);
    drive(1'b0, '0, '0, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_go", 32'(unit_go), 32'd0);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd1);
    clear_model();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      check("post_rst_valid", 32'(out_valid), 32'd0);
      check("post_rst_go", 32'(unit_go), 32'd0);
    end
    drive(1'b1, 32'd9, 32'd3, 1'b1);
    run_until_out("div_after_reset", 40, 32'd3);

    // Randomized traffic against the scoreboard for both unit kinds.
    div_lat_fixed = 0;
    for (int m = 0; m < 2; m++) begin
      mode = (m == 0) ? U_MUL : U_DIV;
      for (int i = 0; i < 800; i++)
        drive(1'($urandom_range(0, 1)), $urandom,
              (mode == U_MUL) ? $urandom : $urandom_range(1, 255),
              1'($urandom_range(0, 3) != 0));
      for (int i = 0; i < 300; i++) begin
        if (exp_q.size() == 0 && !busy && n_push == n_issue) break;
        drive(1'b0, '0, '0, 1'b1);
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      check("drain_push_issue", 32'(n_issue), 32'(n_push));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/std_op_sequencer.md
STD_OP_SEQUENCER -- requirements
Module: std_op_sequencer

Interface
REQ-001 Parameter: width, 32, operand/result bit width for all data ports.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  reset is asynchronous and active-low; asserted (0) forces the reset state immediately, regardless of clk.
REQ-004 Port: in_valid  input  1  upstream operand pair present.
REQ-005 Port: in_ready  output  1  operand FIFO can accept (not full).
REQ-006 Port: in_left, in_right  input  width  operands.
REQ-007 Port: unit_go  output  1  registered go to an attached go/done multicycle arithmetic unit.
REQ-008 Port: unit_left, unit_right  output  width  registered operands to the unit, stable while unit_go=1.
REQ-009 Port: unit_out  input  width  unit result, valid only in cycles where unit_done=1.
REQ-010 Port: unit_done  input  1  unit completion pulse.
REQ-011 Port: out_valid  output  1  result register full.
REQ-012 Port: out_ready  input  1  downstream accepts result.
REQ-013 Port: out_data  output  width  held result.
REQ-014 Port: busy  output  1  high in any FSM state other than IDLE.

Function
REQ-015 SHALL contain a 2-entry operand FIFO; push on in_valid&&in_ready, pop only on IDLE->ISSUE transition; simultaneous push and pop when full is NOT allowed (in_ready=0 when full, even during a pop cycle).
REQ-016 SHALL implement FSM states IDLE, ISSUE, RELEASE.
REQ-017 IDLE->ISSUE SHALL occur when FIFO non-empty and result register empty (out_valid=0, or out_valid&&out_ready in the same cycle); FIFO head is registered into unit_left/unit_right and unit_go<=1 on that edge.
REQ-018 In ISSUE, unit_go SHALL remain 1 and operands SHALL remain unchanged until unit_done=1 is sampled.
REQ-019 On sampling unit_done=1 in ISSUE: out_data<=unit_out, out_valid<=1, unit_go<=0, unit_left/unit_right<=0, state->RELEASE.
REQ-020 RELEASE SHALL last exactly one cycle with unit_go=0 (re-arms go/done units that restart while go stays high), then ->IDLE.
REQ-021 unit_done sampled high outside ISSUE SHALL be ignored.
REQ-022 At most one operation SHALL be in flight; minimum issue-to-issue spacing = unit latency + 2 cycles.
REQ-023 Result register SHALL clear out_valid on out_valid&&out_ready; out_data retains its value until next capture.
REQ-024 Back-to-back in IDLE: if result is consumed in the same cycle the FSM evaluates REQ-017, issue SHALL proceed that cycle.
REQ-025 Ordering: results SHALL emerge in operand-acceptance order; no drops, no duplicates.
REQ-026 No arithmetic on data; widths pass through unchanged.

Reset
REQ-027 While reset=0: state=IDLE, FIFO empty, in_ready=1 once reset releases (0 not required during reset), unit_go=0, unit_left=unit_right=0, out_valid=0, out_data=0, busy=0.
REQ-028 Reset asserted mid-ISSUE SHALL drop unit_go to 0 asynchronously and discard the in-flight operation and FIFO contents; no result emerges after release.
REQ-029 First push SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-030 Attach width-32 pipelined multiplier (3-cycle go->done); push (6,7), out_ready=1 -> out_valid=1 with out_data=42, one pulse; unit_go low exactly one cycle after done.
REQ-031 Attach iterative divider; push (100,7),(45,9),(0,5) back-to-back -> in_ready=0 after second push until first pop; outputs 14,5,0 in order.
REQ-032 out_ready=0 with result held, two more pairs pushed -> FIFO full, in_ready=0, unit_go stays 0, out_data stable; raise out_ready -> next issue in the same cycle as consumption.
REQ-033 Spurious unit_done=1 pulse in IDLE -> out_valid stays 0, no state change.
REQ-034 Assert reset 2 cycles into ISSUE of (100,7) -> unit_go=0 immediately, out_valid=0, FIFO empty; post-release push (9,3) to divider -> out_data=3.
